// File: rtl/serial_cap_pkg.sv
// Shared types and constants for the serial word capture front end.
package serial_cap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic START_LVL     = 1'b1;

endpackage

// File: rtl/serial_word_capture_buffer.sv
// Single-entry valid/ready output register; a word completing while the entry
// is occupied and not being drained is dropped and flagged as an overrun.
module word_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             free;

  always_comb begin
    free    = !valid_q || ready_i;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr_i) ovr_d = 1'b0;
    // A set on the same edge as a clear wins, so no drop goes unreported.
    if (load_i && free) begin
      word_d  = word_i;
      valid_d = 1'b1;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      if (load_i)             ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign word_o    = word_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_word_capture.sv
// Start-bit framed serial-to-parallel capture with a valid/ready output buffer.
// Optional even-parity bit after the data is enabled by SERIAL_WORD_CAPTURE_PARITY_EN.
module serial_word_capture
  import serial_cap_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             D_IN,
  output logic [WIDTH-1:0] WORD_OUT,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             BUSY,
  output logic             OVERRUN,
  input  logic             CLR_OVR,
  output logic             PARITY_ERR
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] load_word;
  logic             load;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Shift register contents including the bit being sampled on this edge.
  assign shift_in = MSB_FIRST ? {shift_q[WIDTH-2:0], D_IN} : {D_IN, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    load_word = shift_in;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    perr_d    = 1'b0;
`endif
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (D_IN == START_LVL) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          shift_d = shift_in;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            load    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
        PARITY: begin
          state_d   = IDLE;
          load_word = shift_q;
          if ((^shift_q ^ D_IN) == 1'b0) load   = 1'b1;
          else                           perr_d = 1'b1;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign PARITY_ERR = perr_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign BUSY = (state_q != IDLE);

  word_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load_i   (load),
    .word_i   (load_word),
    .ready_i  (WORD_READY),
    .clr_ovr_i(CLR_OVR),
    .word_o   (WORD_OUT),
    .valid_o  (WORD_VALID),
    .overrun_o(OVERRUN)
  );

endmodule

// File: tb/tb_serial_word_capture.sv
// Directed bench for serial_word_capture; an LSB-first twin shares all inputs.
module tb_serial_word_capture;

  localparam int W = 8;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         EN = 1'b0;
  logic         D_IN = 1'b0;
  logic         WORD_READY = 1'b0;
  logic         CLR_OVR = 1'b0;
  logic [W-1:0] WORD_OUT, word_lsb;
  logic         WORD_VALID, BUSY, OVERRUN, PARITY_ERR;
  logic         valid_lsb, busy_lsb, ovr_lsb, perr_lsb;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_word_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .D_IN(D_IN),
    .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .CLR_OVR(CLR_OVR), .PARITY_ERR(PARITY_ERR)
  );

  serial_word_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .D_IN(D_IN),
    .WORD_OUT(word_lsb), .WORD_VALID(valid_lsb), .WORD_READY(WORD_READY),
    .BUSY(busy_lsb), .OVERRUN(ovr_lsb), .CLR_OVR(CLR_OVR), .PARITY_ERR(perr_lsb)
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Start bit, data MSB of w first, optional parity; ready/clear apply to the final edge.
  task automatic send_frame(input logic [7:0] w, input bit rdy_last, input bit clr_last,
                            input bit bad_par);
    logic [8:0] bits;
    for (int i = 0; i < 8; i++) bits[i] = w[7-i];
    bits[8] = (^w) ^ bad_par;
    EN = 1'b1;
    D_IN = 1'b1;
    step;
    for (int i = 0; i < NB; i++) begin
      D_IN = bits[i];
      if (i == NB - 1) begin
        WORD_READY = rdy_last;
        CLR_OVR = clr_last;
      end
      step;
    end
    D_IN = 1'b0;
    CLR_OVR = 1'b0;
    $display("frame %h sent", w);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", WORD_VALID); end
    checks++; if (WORD_OUT !== 8'h00) begin errors++; $display("FAIL rst_word got %h want 00", WORD_OUT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", OVERRUN); end
    checks++; if (PARITY_ERR !== 1'b0) begin errors++; $display("FAIL rst_perr got %b want 0", PARITY_ERR); end
    RST_N = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [7:0] w;
    logic [8:0] bits;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) bits[i] = w[7-i];
    bits[8] = ^w;
    WORD_READY = 1'b1;
    EN = 1'b1;
    D_IN = 1'b1;
    step;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", BUSY); end
    for (int i = 0; i < NB; i++) begin
      D_IN = bits[i];
      if (i == NB - 1) begin
        checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", WORD_VALID); end
      end
      step;
    end
    D_IN = 1'b0;
    checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", WORD_VALID); end
    checks++; if (WORD_OUT !== 8'hA5) begin errors++; $display("FAIL basic_word got %h want a5", WORD_OUT); end
    checks++; if (word_lsb !== 8'hA5) begin errors++; $display("FAIL basic_lsb_word got %h want a5", word_lsb); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", BUSY); end
    step;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", WORD_VALID); end
    $display("test_basic done");
  endtask

  task automatic test_bit_order;
    WORD_READY = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h11) begin errors++; $display("FAIL order_msb got %h want 11", WORD_OUT); end
    checks++; if (word_lsb !== 8'h88) begin errors++; $display("FAIL order_lsb got %h want 88", word_lsb); end
    checks++; if (valid_lsb !== 1'b1) begin errors++; $display("FAIL order_lsb_valid got %b want 1", valid_lsb); end
    step;
    $display("test_bit_order done");
  endtask

  task automatic test_backpressure;
    WORD_READY = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h3C) begin errors++; $display("FAIL bp_word1 got %h want 3c", WORD_OUT); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL bp_ovr1 got %b want 0", OVERRUN); end
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h3C) begin errors++; $display("FAIL bp_word2 got %h want 3c", WORD_OUT); end
    checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid2 got %b want 1", WORD_VALID); end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL bp_ovr2 got %b want 1", OVERRUN); end
    WORD_READY = 1'b1;
    step;
    WORD_READY = 1'b0;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL bp_accept got %b want 0", WORD_VALID); end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", OVERRUN); end
    CLR_OVR = 1'b1;
    step;
    CLR_OVR = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", OVERRUN); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL bp_set_wins got %b want 1", OVERRUN); end
    WORD_READY = 1'b1;
    CLR_OVR = 1'b1;
    step;
    CLR_OVR = 1'b0;
    WORD_READY = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL bp_clear2 got %b want 0", OVERRUN); end
    $display("test_backpressure done");
  endtask

  task automatic test_accept_load;
    WORD_READY = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h11) begin errors++; $display("FAIL al_hold got %h want 11", WORD_OUT); end
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    WORD_READY = 1'b0;
    checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL al_valid got %b want 1", WORD_VALID); end
    checks++; if (WORD_OUT !== 8'h22) begin errors++; $display("FAIL al_word got %h want 22", WORD_OUT); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL al_ovr got %b want 0", OVERRUN); end
    WORD_READY = 1'b1;
    step;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL al_drain got %b want 0", WORD_VALID); end
    $display("test_accept_load done");
  endtask

  task automatic test_en_gating;
    logic [7:0] w;
    logic [8:0] bits;
    w = 8'h5A;
    for (int i = 0; i < 8; i++) bits[i] = w[7-i];
    bits[8] = ^w;
    WORD_READY = 1'b1;
    EN = 1'b0;
    D_IN = 1'b1;
    step;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL en_idle_start got %b want 0", BUSY); end
    EN = 1'b1;
    step;
    for (int i = 0; i < NB; i++) begin
      EN = 1'b0;
      D_IN = ~bits[i];
      step;
      checks++; if (BUSY !== 1'b1 || WORD_VALID !== 1'b0) begin
        errors++; $display("FAIL en_hold bit %0d got busy %b valid %b want 1 0", i, BUSY, WORD_VALID);
      end
      EN = 1'b1;
      D_IN = bits[i];
      step;
    end
    D_IN = 1'b0;
    checks++; if (WORD_VALID !== 1'b1) begin errors++; $display("FAIL en_valid got %b want 1", WORD_VALID); end
    checks++; if (WORD_OUT !== 8'h5A) begin errors++; $display("FAIL en_word got %h want 5a", WORD_OUT); end
    EN = 1'b0;
    step;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL en_accept got %b want 0", WORD_VALID); end
    EN = 1'b1;
    $display("test_en_gating done");
  endtask

  task automatic test_back_to_back;
    WORD_READY = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h81 || WORD_VALID !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h valid %b want 81 1", WORD_OUT, WORD_VALID);
    end
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h7E || WORD_VALID !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h valid %b want 7e 1", WORD_OUT, WORD_VALID);
    end
    step;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midframe;
    WORD_READY = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    D_IN = 1'b1; step;
    D_IN = 1'b1; step;
    D_IN = 1'b0; step;
    D_IN = 1'b1; step;
    #2;
    RST_N = 1'b0;
    D_IN = 1'b0;
    #1;
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", WORD_VALID); end
    checks++; if (WORD_OUT !== 8'h00) begin errors++; $display("FAIL mid_word got %h want 00", WORD_OUT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", BUSY); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL mid_ovr got %b want 0", OVERRUN); end
    #1;
    RST_N = 1'b1;
    step;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_post_busy got %b want 0", BUSY); end
    WORD_READY = 1'b1;
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h96 || WORD_VALID !== 1'b1) begin
      errors++; $display("FAIL mid_recap got %h valid %b want 96 1", WORD_OUT, WORD_VALID);
    end
    step;
    $display("test_reset_midframe done");
  endtask

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  task automatic test_parity;
    WORD_READY = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    checks++; if (WORD_OUT !== 8'h07 || WORD_VALID !== 1'b1) begin
      errors++; $display("FAIL par_good got %h valid %b want 07 1", WORD_OUT, WORD_VALID);
    end
    checks++; if (PARITY_ERR !== 1'b0) begin errors++; $display("FAIL par_good_err got %b want 0", PARITY_ERR); end
    step;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    checks++; if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL par_bad_valid got %b want 0", WORD_VALID); end
    checks++; if (PARITY_ERR !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b want 1", PARITY_ERR); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL par_bad_ovr got %b want 0", OVERRUN); end
    step;
    checks++; if (PARITY_ERR !== 1'b0) begin errors++; $display("FAIL par_pulse got %b want 0", PARITY_ERR); end
    $display("test_parity done");
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_bit_order;
    test_backpressure;
    test_accept_load;
    test_en_gating;
    test_back_to_back;
    test_reset_midframe;
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_capture.md
Name: serial_word_capture

Overview:
- Receive-side counterpart to the serial D-stream stimulus used on the flip-flop benches. Samples a single-bit serial line on CLK, detects a start bit, and assembles WIDTH data bits into a parallel word.
- Presents each word through a valid/ready output buffer.
- Sits after any D flip-flop or serial source under test, as a capture/checker front end.

Parameters:
- WIDTH, 8, data bits per frame (2..32)
- MSB_FIRST, 1, 1 = first received data bit lands in WORD_OUT[WIDTH-1]; 0 = lands in WORD_OUT[0]

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  sample enable; when 0, FSM, counter and shift register hold
- D_IN  input  1  serial data line
- WORD_OUT  output  WIDTH  captured word; stable while WORD_VALID=1
- WORD_VALID  output  1  word available in output buffer
- WORD_READY  input  1  consumer accepts word when WORD_VALID & WORD_READY at a rising edge
- BUSY  output  1  1 while FSM is not in IDLE
- OVERRUN  output  1  sticky; set when a completed word is dropped
- CLR_OVR  input  1  synchronous clear of OVERRUN
- PARITY_ERR  output  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (RST_N=0, async): state=IDLE; bit counter=0; shift reg=0; WORD_OUT=0; WORD_VALID=0; BUSY=0; OVERRUN=0; PARITY_ERR=0. Reset mid-frame discards the partial word. A held buffer word is also lost.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE: on an edge with EN=1 and D_IN=1 (start bit), go to SHIFT with count=0. D_IN=0 stays in IDLE.
- SHIFT: each edge with EN=1 samples D_IN into the shift register per MSB_FIRST and increments count. On the sample with count=WIDTH-1, the frame is complete.
  - Without the macro, go to IDLE.
  - With the macro, go to PARITY.
- EN=0 in any state: no transition, no sample, no count change. The buffer handshake still operates.
- Frame completion, evaluated at the edge of the final sample:
  - Buffer free (WORD_VALID=0, or WORD_VALID & WORD_READY this same edge): load WORD_OUT and set WORD_VALID=1, visible the cycle after the last bit.
  - Otherwise: new word discarded, WORD_OUT unchanged, OVERRUN←1.
- Latency: WIDTH+1 enabled cycles from start-bit sample to WORD_VALID (WIDTH+2 with parity).
- Handshake:
  - WORD_VALID deasserts the edge after acceptance unless a new word loads on that same edge. In that case WORD_VALID stays 1 and WORD_OUT updates.
  - WORD_VALID never drops without acceptance.
- Back-to-back frames: a start bit may be sampled in the cycle immediately after return to IDLE. No gap is required.
- OVERRUN: CLR_OVR=1 clears it. A simultaneous set and clear leaves it set.
- Count width: $clog2(WIDTH). Count wraps to 0 on frame completion.

Optional Feature:
- Macro: SERIAL_WORD_CAPTURE_PARITY_EN.
- Defined:
  - After WIDTH data bits, one extra enabled sample in PARITY is an even-parity bit. XOR of data and parity must equal 0.
  - Match: completion rules as above.
  - Mismatch: word discarded, buffer untouched, PARITY_ERR=1 for exactly one cycle, OVERRUN unaffected.
  - Then go to IDLE.
- Undefined: no PARITY state, PARITY_ERR tied 0, frame is start bit plus WIDTH bits.

Decomposition:
- Shared package serial_cap_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - localparam for the default WIDTH
  - start-bit level constant START_LVL=1
- One natural sub-module, word_out_buffer: single-entry valid/ready register with load/accept/overrun logic.
- FSM and shifter stay in the top.

Test Plan:
- Reset: RST_N low mid-frame after 3 bits, release -> all outputs 0, FSM IDLE. The next full frame is captured correctly.
- Basic capture: WIDTH=8, MSB_FIRST=1, EN=1, WORD_READY=1, D_IN = 1 then 1,0,1,0,0,1,0,1 -> WORD_OUT=8'hA5, WORD_VALID high for 1 cycle, 9 cycles after the start-bit sample. With MSB_FIRST=0 the same stream gives 8'hA5 bit-reversed, 8'hA5.
- Backpressure/overrun: WORD_READY=0, send 8'h3C then 8'hC3 -> WORD_OUT stays 8'h3C, OVERRUN=1. Raise WORD_READY -> valid drops. CLR_OVR pulse -> OVERRUN=0.
- Simultaneous accept+load: hold 8'h11, assert WORD_READY on the exact edge 8'h22 completes -> WORD_VALID stays 1, WORD_OUT=8'h22, OVERRUN=0.
- EN gating: toggle EN 0/1 every cycle during a frame of 8'h5A -> result is still 8'h5A. Latency equals 9 enabled cycles.
- Parity (macro defined): 8'h07 with parity bit 1 -> captured. 8'h07 with parity bit 0 -> no WORD_VALID, PARITY_ERR one-cycle pulse.
